// File: rtl/sampler_ctrl_pkg.sv
// Shared definitions for the sample capture controller: state encoding and default sizing.
package sampler_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    STOP    = 2'd3
  } state_t;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_STOP_CYCLES = 2;

endpackage

// File: rtl/sample_capture_ctrl_trig_match.sv
// Trigger detector: registers data_in, selects one channel and does the mask/value compare.
// With SAMPLE_TRIG_EDGE_EN defined it also keeps a previous-match flag for entry triggering.
module trig_match #(
  parameter int CHANNEL   = 16,
  parameter int DATA_BITS = 16,
  parameter int CHAN_W    = $clog2(CHANNEL)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           armed,
`ifdef SAMPLE_TRIG_EDGE_EN
  input  logic                           clear,
  input  logic                           edge_en,
`endif
  input  logic [CHAN_W-1:0]              chan,
  input  logic [DATA_BITS-1:0]           mask,
  input  logic [DATA_BITS-1:0]           value,
  input  logic [DATA_BITS*CHANNEL-1:0]   data_in,
  output logic                           hit
);

  logic [DATA_BITS*CHANNEL-1:0] data_q;
  logic                         valid_q;
  logic [CHAN_W-1:0]            chan_sel;
  logic [DATA_BITS-1:0]         word;
  logic                         match;

  // valid_q marks a sample that was registered while ARMED, so the sample
  // taken on the arm edge itself never counts as a trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_in;
      valid_q <= armed;
    end
  end

  always_comb begin
    chan_sel = (int'(chan) < CHANNEL) ? chan : '0;
    word     = data_q[chan_sel*DATA_BITS +: DATA_BITS];
    match    = ((word ^ value) & mask) == '0;
  end

`ifdef SAMPLE_TRIG_EDGE_EN
  logic prev_q;

  // History starts from the sample present at arm, so a level already true then cannot fire.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev_q <= 1'b0;
    end else if (armed) begin
      prev_q <= match;
    end
  end

  assign hit = armed && valid_q && match && !(edge_en && prev_q);
`else
  assign hit = armed && valid_q && match;
`endif

endmodule

// File: rtl/sample_capture_ctrl.sv
// Capture sequencing controller: arm/force/abort commands, trigger, start/stop pulses, sample count.
// Optional entry (edge) triggering with the cfg_trig_edge port is enabled by SAMPLE_TRIG_EDGE_EN.
module sample_capture_ctrl
  import sampler_ctrl_pkg::*;
#(
  parameter int CHANNEL     = 16,
  parameter int DATA_BITS   = 16,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STOP_CYCLES = DEF_STOP_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_arm,
  input  logic                          cmd_force,
  input  logic                          cmd_abort,
  input  logic [$clog2(CHANNEL)-1:0]    cfg_trig_chan,
  input  logic [DATA_BITS-1:0]          cfg_trig_mask,
  input  logic [DATA_BITS-1:0]          cfg_trig_value,
  input  logic [CNT_W-1:0]              cfg_length,
`ifdef SAMPLE_TRIG_EDGE_EN
  input  logic                          cfg_trig_edge,
`endif
  input  logic [DATA_BITS*CHANNEL-1:0]  data_in,
  output logic                          start_sample,
  output logic                          stop_sample,
  output logic                          busy,
  output logic                          triggered,
  output logic                          done,
  output logic [CNT_W-1:0]              sample_count
);

  localparam int CHAN_W = $clog2(CHANNEL);
  localparam int STOP_W = $clog2(STOP_CYCLES + 1);

  state_t               state_q, state_d;
  logic [CHAN_W-1:0]    chan_q;
  logic [DATA_BITS-1:0] mask_q;
  logic [DATA_BITS-1:0] value_q;
  logic [CNT_W-1:0]     length_q;
  logic [CNT_W-1:0]     count_q;
  logic [STOP_W-1:0]    stop_cnt_q;
  logic                 done_q;
  logic                 arm_accept;
  logic                 hit;

  assign arm_accept = (state_q == IDLE) && cmd_arm;

`ifdef SAMPLE_TRIG_EDGE_EN
  logic edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q <= 1'b0;
    end else if (arm_accept) begin
      edge_q <= cfg_trig_edge;
    end
  end
`endif

  trig_match #(
    .CHANNEL   (CHANNEL),
    .DATA_BITS (DATA_BITS),
    .CHAN_W    (CHAN_W)
  ) u_trig_match (
    .clk     (clk),
    .reset   (reset),
    .armed   (state_q == ARMED),
`ifdef SAMPLE_TRIG_EDGE_EN
    .clear   (arm_accept),
    .edge_en (edge_q),
`endif
    .chan    (chan_q),
    .mask    (mask_q),
    .value   (value_q),
    .data_in (data_in),
    .hit     (hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_arm) state_d = ARMED;
      end
      ARMED: begin
        if (cmd_abort)             state_d = IDLE;
        else if (cmd_force || hit) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (cmd_abort) state_d = STOP;
        else if ((length_q != '0) && (count_q == length_q - CNT_W'(1))) state_d = STOP;
      end
      STOP: begin
        if (stop_cnt_q == STOP_W'(STOP_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The count only advances while CAPTURE continues, so it freezes at its final value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      chan_q     <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      length_q   <= '0;
      count_q    <= '0;
      stop_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= (state_q == STOP) && (state_d == IDLE);
      stop_cnt_q <= (state_q == STOP) ? stop_cnt_q + STOP_W'(1) : '0;
      if (arm_accept) begin
        chan_q   <= cfg_trig_chan;
        mask_q   <= cfg_trig_mask;
        value_q  <= cfg_trig_value;
        length_q <= cfg_length;
        count_q  <= '0;
      end else if ((state_q == CAPTURE) && (state_d == CAPTURE) && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign start_sample = (state_q == CAPTURE) && (count_q == '0);
  assign stop_sample  = (state_q == STOP);
  assign busy         = (state_q != IDLE);
  assign triggered    = (state_q == CAPTURE) || (state_q == STOP);
  assign done         = done_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Self-checking bench for sample_capture_ctrl: directed scenarios plus randomized triggers.
module tb_sample_capture_ctrl;

  localparam int CH = 16;
  localparam int DB = 16;
  localparam int CW = 5;
  localparam int SC = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_arm, cmd_force, cmd_abort;
  logic [3:0]      cfg_trig_chan;
  logic [DB-1:0]   cfg_trig_mask, cfg_trig_value;
  logic [CW-1:0]   cfg_length;
  logic [DB*CH-1:0] data_in;
  logic            start_sample, stop_sample, busy, triggered, done;
  logic [CW-1:0]   sample_count;

  int errors = 0;
  int checks = 0;

  sample_capture_ctrl #(
    .CHANNEL(CH), .DATA_BITS(DB), .CNT_W(CW), .STOP_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_arm(cmd_arm), .cmd_force(cmd_force), .cmd_abort(cmd_abort),
    .cfg_trig_chan(cfg_trig_chan), .cfg_trig_mask(cfg_trig_mask),
    .cfg_trig_value(cfg_trig_value), .cfg_length(cfg_length),
`ifdef SAMPLE_TRIG_EDGE_EN
    .cfg_trig_edge(1'b0),
`endif
    .data_in(data_in),
    .start_sample(start_sample), .stop_sample(stop_sample), .busy(busy),
    .triggered(triggered), .done(done), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic st, input logic sp, input logic b,
                          input logic tr, input logic d, input int cnt);
    checkOutput({tag, ".start"}, 32'(start_sample), 32'(st));
    checkOutput({tag, ".stop"}, 32'(stop_sample), 32'(sp));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
    checkOutput({tag, ".triggered"}, 32'(triggered), 32'(tr));
    checkOutput({tag, ".done"}, 32'(done), 32'(d));
    checkOutput({tag, ".count"}, 32'(sample_count), 32'(cnt));
  endtask

  task automatic applyStimulus(input logic a, input logic f, input logic ab);
    cmd_arm = a; cmd_force = f; cmd_abort = ab;
    tick();
    cmd_arm = 1'b0; cmd_force = 1'b0; cmd_abort = 1'b0;
  endtask

  function automatic bit isMatch(input logic [DB-1:0] w, input logic [DB-1:0] m, input logic [DB-1:0] v);
    return ((w ^ v) & m) == '0;
  endfunction

  function automatic int satCount(input int k);
    return (k > (1 << CW) - 1) ? (1 << CW) - 1 : k;
  endfunction

  task automatic randomBus();
    for (int k = 0; k < DB * CH / 32; k++) data_in[k*32 +: 32] = $urandom;
  endtask

  // Arms with the given config, scrambles the config inputs, then feeds samples until the
  // model says a trigger has happened (a match two edges earlier, or a force one edge earlier).
  task automatic armAndTrigger(input int chan, input logic [DB-1:0] mask, input logic [DB-1:0] value,
                               input int len, input int match_at, input int force_at);
    bit prev_match;
    bit started;
    bit f;
    bit want;
    logic [DB-1:0] w;
    logic [DB-1:0] low;
    cfg_trig_chan  = 4'(chan);
    cfg_trig_mask  = mask;
    cfg_trig_value = value;
    cfg_length     = CW'(len);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkAll("armed", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    cfg_trig_chan  = 4'($urandom);
    cfg_trig_mask  = 16'($urandom);
    cfg_trig_value = 16'($urandom);
    cfg_length     = CW'($urandom);
    prev_match = 1'b0;
    started    = 1'b0;
    for (int i = 0; i < 40 && !started; i++) begin
      randomBus();
      w = 16'($urandom);
      want = (match_at < 0) ? ($urandom_range(0, 3) == 0) : (i == match_at);
      if (want) begin
        w = (value & mask) | (w & ~mask);
      end else if (isMatch(w, mask, value) && mask != '0) begin
        low = mask & (~mask + 16'd1);
        w = w ^ low;
      end
      data_in[chan*DB +: DB] = w;
      f = (i == force_at) || (i == 39);
      cmd_force = f;
      tick();
      cmd_force = 1'b0;
      checkOutput($sformatf("wait%0d.start", i), 32'(start_sample), 32'(prev_match | f));
      checkOutput($sformatf("wait%0d.busy", i), 32'(busy), 32'd1);
      started = prev_match | f;
      prev_match = isMatch(w, mask, value);
    end
  endtask

  // Called in the first CAPTURE cycle; walks the capture, stop and done phases.
  task automatic expectCapture(input int len, input int abort_after, input bit arm_with_abort,
                               input bit abort_in_stop);
    bit aborting;
    int n;
    int fin;
    aborting = (abort_after > 0) && (len == 0 || abort_after < len);
    n = aborting ? abort_after : len;
    fin = satCount(n - 1);
    for (int k = 0; k < n; k++) begin
      randomBus();
      checkAll($sformatf("cap%0d", k), k == 0, 1'b0, 1'b1, 1'b1, 1'b0, satCount(k));
      if (k == n - 1 && aborting) begin
        cmd_abort = 1'b1;
        cmd_arm   = arm_with_abort;
      end
      tick();
      cmd_abort = 1'b0;
      cmd_arm   = 1'b0;
    end
    for (int s = 0; s < SC; s++) begin
      checkAll($sformatf("stop%0d", s), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, fin);
      if (s == 0 && abort_in_stop) cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
    end
    checkAll("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fin);
    tick();
    checkAll("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fin);
  endtask

  initial begin
    int len;
    int abort_after;
    logic [DB-1:0] m;

    reset = 1'b1;
    cmd_arm = 1'b0; cmd_force = 1'b0; cmd_abort = 1'b0;
    cfg_trig_chan = '0; cfg_trig_mask = '0; cfg_trig_value = '0; cfg_length = '0;
    data_in = '0;
    tick();
    tick();
    checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    tick();

    $display("[TB] basic masked trigger, length 4");
    armAndTrigger(3, 16'h00FF, 16'h0042, 4, 3, -1);
    expectCapture(4, 0, 1'b0, 1'b0);

    $display("[TB] force and abort ignored in IDLE");
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkAll("idle_cmds", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    $display("[TB] mask 0, length 1");
    armAndTrigger(7, 16'h0000, 16'h1234, 1, -1, -1);
    expectCapture(1, 0, 1'b0, 1'b0);

    $display("[TB] force on never-matching value, abort in STOP ignored");
    armAndTrigger(5, 16'hFFFF, 16'hBEEF, 3, 100, 2);
    expectCapture(3, 0, 1'b0, 1'b1);

    $display("[TB] abort in ARMED with force in the same cycle");
    cfg_trig_mask = 16'hFFFF; cfg_trig_value = 16'h0000; cfg_trig_chan = 4'd1; cfg_length = CW'(2);
    data_in = '1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkAll("armwait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkAll("abort_armed", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll($sformatf("post_abort%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end

    $display("[TB] unlimited length, abort plus arm after 10 cycles");
    armAndTrigger(9, 16'h0000, 16'h0000, 0, -1, -1);
    expectCapture(0, 10, 1'b1, 1'b0);
    armAndTrigger(2, 16'hF000, 16'hA000, 2, -1, -1);
    expectCapture(2, 0, 1'b0, 1'b0);

    $display("[TB] unlimited length saturation");
    armAndTrigger(15, 16'h0000, 16'h0000, 0, -1, -1);
    expectCapture(0, 40, 1'b0, 1'b0);

    $display("[TB] reset mid-capture");
    armAndTrigger(0, 16'h0000, 16'h0000, 8, -1, -1);
    for (int k = 0; k < 3; k++) begin
      checkAll($sformatf("pre_rst%0d", k), k == 0, 1'b0, 1'b1, 1'b1, 1'b0, k);
      tick();
    end
    reset = 1'b1;
    tick();
    checkAll("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    tick();
    checkAll("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    armAndTrigger(4, 16'h0F0F, 16'h0505, 3, 2, -1);
    expectCapture(3, 0, 1'b0, 1'b0);

    $display("[TB] randomized captures");
    for (int r = 0; r < 10; r++) begin
      m = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      len = $urandom_range(1, 6);
      abort_after = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
      armAndTrigger($urandom_range(0, CH - 1), m, 16'($urandom), len, -1, -1);
      expectCapture(len, abort_after, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_capture_ctrl.md
Name: sample_capture_ctrl

Overview:
- Sequencing controller for the sample-compression/packetizer capture path.
- Takes host commands (arm / force / abort) and a mask/value trigger on one selected input channel.
- Generates the `start_sample` / `stop_sample` pulses that drive the capture state machine, and counts a programmed number of samples.
- Lives in the sample clock domain, next to the capture block, and shares its `data_in` bus.

Parameters:
- CHANNEL, 16, number of sampled channels in `data_in`.
- DATA_BITS, 16, bits per channel word.
- CNT_W, 32, width of the length/sample counter.
- STOP_CYCLES, 2, cycles `stop_sample` is held high; must be >= 1.

Ports:
- clk  in  1  sample clock; all logic is single-clock.
- reset  in  1  synchronous reset, active-high.
- cmd_arm  in  1  one-cycle pulse; latch config and wait for trigger.
- cmd_force  in  1  one-cycle pulse; trigger immediately when ARMED.
- cmd_abort  in  1  one-cycle pulse; cancel the current operation.
- cfg_trig_chan  in  $clog2(CHANNEL)  channel index used for the trigger compare.
- cfg_trig_mask  in  DATA_BITS  bits that take part in the compare.
- cfg_trig_value  in  DATA_BITS  required value of the masked bits.
- cfg_length  in  CNT_W  samples to capture after the trigger; 0 = unlimited.
- data_in  in  DATA_BITS*CHANNEL  live sample bus (channel k = bits [k*DATA_BITS +: DATA_BITS]).
- start_sample  out  1  one-cycle start pulse to the capture block.
- stop_sample  out  1  stop level, held STOP_CYCLES cycles.
- busy  out  1  high in any state other than IDLE.
- triggered  out  1  high in CAPTURE and STOP.
- done  out  1  one-cycle pulse on the STOP->IDLE transition.
- sample_count  out  CNT_W  samples counted since the trigger.

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0; latched config 0.
- States: IDLE, ARMED, CAPTURE, STOP.
- IDLE:
  - On cmd_arm, latch chan/mask/value/length, clear sample_count, go to ARMED next cycle.
  - cmd_force and cmd_abort are ignored.
- ARMED:
  - Match is `((word[chan] ^ value) & mask) == 0`, evaluated on `data_in` registered one stage.
  - A sample present at edge N, if it matches, puts the block in CAPTURE with start_sample=1 during cycle N+2.
  - cmd_force at edge N gives the same result at N+1.
  - mask=0 means the first registered sample matches.
  - A cfg_trig_chan value >= CHANNEL selects channel 0.
- CAPTURE:
  - sample_count increments by 1 every cycle; the first CAPTURE cycle shows 0.
  - If length!=0 and sample_count==length-1: next state is STOP, with stop_sample high from the next cycle.
  - length=1 gives exactly one CAPTURE cycle.
  - If length=0 (unlimited), sample_count saturates at all-ones and does not wrap.
- STOP:
  - stop_sample high for exactly STOP_CYCLES cycles, then IDLE.
  - done=1 in the first IDLE cycle; sample_count keeps its final value until the next arm.
- Priority within a cycle: abort > force > trigger match. cmd_arm is honoured only in IDLE.
- Abort handling:
  - In ARMED: go to IDLE; no start, stop or done is issued.
  - In CAPTURE: go to STOP; the normal stop sequence and done follow.
  - In STOP: ignored.
- Config inputs are sampled only on an accepted arm; later changes have no effect.
- Reset mid-operation: outputs drop to 0 on the next edge. No stop pulse is issued, because the capture block's own reset returns it to idle.
- start_sample and stop_sample are never high in the same cycle.

Optional Feature:
- Macro: SAMPLE_TRIG_EDGE_EN.
- Defined:
  - Adds input `cfg_trig_edge` (1 bit), latched on arm.
  - When 1, the trigger needs a match on the current registered sample and no match on the previous registered sample (entry into the condition).
  - The previous-match flag is cleared on arm, so a level already present at arm does not trigger.
- Not defined: level trigger only; the port is absent.

Decomposition:
- Shared package `sampler_ctrl_pkg` holds:
  - the state encoding (IDLE=0, ARMED=1, CAPTURE=2, STOP=3);
  - the default CNT_W / STOP_CYCLES constants.
- Sub-module `trig_match` holds the input register stage, channel mux, mask compare, and the edge history under the macro. Its output is a 1-bit `hit`.

Test Plan:
- Arm, chan=3, mask=0x00FF, value=0x0042, length=4; drive ch3=0x1142 at edge N -> start_sample at cycle N+2, sample_count 0..3, stop_sample high 2 cycles, done pulse, sample_count stays 3.
- Arm with mask=0x0000, length=1 -> start two cycles after ARMED entry, one CAPTURE cycle, stop 2 cycles, done.
- Arm with a never-matching value, cmd_force -> start_sample the next cycle. Arm again, then cmd_abort in ARMED -> IDLE, no start, stop or done.
- length=0, capture 10 cycles, cmd_abort and cmd_arm in the same cycle -> STOP entered, arm ignored, done after the stop; a later arm is accepted.
- Assert reset mid-CAPTURE -> all outputs 0 next edge, no stop pulse; a fresh arm works normally.
- With SAMPLE_TRIG_EDGE_EN and cfg_trig_edge=1, condition already true at arm -> no trigger until it goes false then true; start follows the rising match by 2 cycles.
